// File: rtl/ibtida_mem_pkg.sv
// Shared types for the Ibtida instruction-memory port arbiter.
package ibtida_mem_pkg;
  localparam int RAM_DW = 32;

  typedef enum logic [1:0] {IDLE, ACC, CAP, RSP} state_e;
  typedef enum logic       {OWN_WB, OWN_LA}      owner_e;
endpackage

// File: rtl/rst_hold_seq.sv
// Core reset sequencer: holds core_rst_no low while programming and for
// RST_HOLD cycles after programming mode ends.
module rst_hold_seq #(
  parameter int unsigned RST_HOLD = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic prog_mode_i,
  output logic core_rst_no
);
  localparam int CW = 16;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          rel_q;

  always_comb begin
    cnt_d = cnt_q;
    if (prog_mode_i)        cnt_d = CW'(RST_HOLD);
    else if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;
  end

  // Release is registered off the next count so it never glitches on reload.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= CW'(RST_HOLD);
      rel_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rel_q <= !prog_mode_i && (cnt_d == '0);
    end
  end

  assign core_rst_no = rel_q;
endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the single-port instruction RAM between the Wishbone slave and the
// LA programming port; round-robin arbitration, fixed 4-cycle access.
module imem_port_arbiter
  import ibtida_mem_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter logic [31:0] WB_BASE  = 32'h3000_0000,
  parameter int unsigned RST_HOLD = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              prog_mode_i,
  input  logic              la_req_i,
  input  logic              la_we_i,
  input  logic [ADDR_W-1:0] la_addr_i,
  input  logic [31:0]       la_wdata_i,
  output logic              la_ack_o,
  output logic [31:0]       la_rdata_o,
  output logic              ram_en_o,
  output logic [3:0]        ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i,
  output logic              core_rst_no
);
  state_e              state_q;
  owner_e              owner_q, last_q;
  logic                wr_q, abort_q, wb_busy_q;
  logic                wbs_ack_q, la_ack_q, ram_en_q;
  logic [RAM_DW-1:0]   wbs_dat_q, la_rdata_q, ram_wdata_q;
  logic [3:0]          ram_we_q;
  logic [ADDR_W-1:0]   ram_addr_q;

  logic wb_hit, wb_valid, wb_pend, wb_miss, la_pend, grant_la;
  logic [RAM_DW-1:0] cap_data;
  logic unused_adr;

  assign unused_adr = ^wbs_adr_i[1:0];
  assign wb_hit   = (wbs_adr_i[31:ADDR_W+2] == WB_BASE[31:ADDR_W+2]);
  assign wb_valid = wbs_cyc_i && wbs_stb_i && !wb_busy_q;
  assign wb_pend  = wb_valid && wb_hit;
  assign wb_miss  = wb_valid && !wb_hit;
  assign la_pend  = la_req_i && !la_ack_q && prog_mode_i;
  assign grant_la = la_pend && (!wb_pend || last_q == OWN_WB);
  assign cap_data = wr_q ? '0 : ram_rdata_i;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= IDLE;
      owner_q     <= OWN_WB;
      last_q      <= OWN_LA;
      wr_q        <= 1'b0;
      abort_q     <= 1'b0;
      wb_busy_q   <= 1'b0;
      wbs_ack_q   <= 1'b0;
      wbs_dat_q   <= '0;
      la_ack_q    <= 1'b0;
      la_rdata_q  <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      wbs_ack_q <= 1'b0;
      wbs_dat_q <= '0;
      // A WB request stays "in flight" through its ack cycle so a master
      // still holding stb during ack is not serviced twice.
      if (wbs_ack_q) wb_busy_q <= 1'b0;
      if (wb_miss) begin
        wbs_ack_q <= 1'b1;
        wb_busy_q <= 1'b1;
      end
      if (la_ack_q && !la_req_i) begin
        la_ack_q   <= 1'b0;
        la_rdata_q <= '0;
      end

      case (state_q)
        IDLE: if (wb_pend || la_pend) begin
          state_q  <= ACC;
          ram_en_q <= 1'b1;
          abort_q  <= 1'b0;
          if (grant_la) begin
            owner_q     <= OWN_LA;
            last_q      <= OWN_LA;
            wr_q        <= la_we_i;
            ram_we_q    <= la_we_i ? 4'hF : 4'h0;
            ram_addr_q  <= la_addr_i;
            ram_wdata_q <= la_wdata_i;
          end else begin
            owner_q     <= OWN_WB;
            last_q      <= OWN_WB;
            wb_busy_q   <= 1'b1;
            wr_q        <= wbs_we_i;
            ram_we_q    <= wbs_we_i ? wbs_sel_i : 4'h0;
            ram_addr_q  <= wbs_adr_i[ADDR_W+1:2];
            ram_wdata_q <= wbs_dat_i;
          end
        end
        ACC: begin
          state_q     <= CAP;
          ram_en_q    <= 1'b0;
          ram_we_q    <= '0;
          ram_addr_q  <= '0;
          ram_wdata_q <= '0;
          if (owner_q == OWN_WB && !wbs_cyc_i) abort_q <= 1'b1;
        end
        CAP: begin
          state_q <= RSP;
          if (owner_q == OWN_WB) begin
            if (abort_q || !wbs_cyc_i) begin
              wb_busy_q <= 1'b0;
            end else begin
              wbs_ack_q <= 1'b1;
              wbs_dat_q <= cap_data;
            end
          end else begin
            la_ack_q   <= 1'b1;
            la_rdata_q <= cap_data;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wbs_ack_o   = wbs_ack_q;
  assign wbs_dat_o   = wbs_dat_q;
  assign la_ack_o    = la_ack_q;
  assign la_rdata_o  = la_rdata_q;
  assign ram_en_o    = ram_en_q;
  assign ram_we_o    = ram_we_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;

  rst_hold_seq #(.RST_HOLD(RST_HOLD)) u_rst_hold (
    .clk_i       (wb_clk_i),
    .rst_ni      (wb_rst_ni),
    .prog_mode_i (prog_mode_i),
    .core_rst_no (core_rst_no)
  );
endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a byte-masked RAM model.
module tb_imem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        prog, la_req, la_we;
  logic [7:0]  la_addr;
  logic [31:0] la_wdata;
  logic        la_ack_o;
  logic [31:0] la_rdata_o;
  logic        ram_en_o;
  logic [3:0]  ram_we_o;
  logic [7:0]  ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata = 32'h0;
  logic        core_rst_no;

  logic [31:0] mem [0:255] = '{default: 32'h0};

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  imem_port_arbiter #(.ADDR_W(8), .WB_BASE(32'h3000_0000), .RST_HOLD(16)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .prog_mode_i(prog), .la_req_i(la_req), .la_we_i(la_we), .la_addr_i(la_addr),
    .la_wdata_i(la_wdata), .la_ack_o(la_ack_o), .la_rdata_o(la_rdata_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata), .core_rst_no(core_rst_no)
  );

  // Single-port RAM: read data one cycle after enable, old data on write.
  always @(posedge clk) begin
    if (ram_en_o) begin
      ram_rdata <= mem[ram_addr_o];
      for (int b = 0; b < 4; b++)
        if (ram_we_o[b]) mem[ram_addr_o][8*b +: 8] = ram_wdata_o[8*b +: 8];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output int lat, output logic [31:0] rd,
                         output int en_cnt, output logic [31:0] a_seen,
                         output logic [31:0] we_seen, output logic [31:0] wd_seen);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
    lat = -1; rd = 32'h0; en_cnt = 0; a_seen = 32'h0; we_seen = 32'h0; wd_seen = 32'h0;
    for (int k = 1; k <= 8 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (ram_en_o) begin
        en_cnt++;
        a_seen = 32'(ram_addr_o); we_seen = 32'(ram_we_o); wd_seen = ram_wdata_o;
      end
      if (wbs_ack_o) begin lat = k; rd = wbs_dat_o; end
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    chk("wb ack single pulse", 32'(wbs_ack_o), 32'h0);
  endtask

  task automatic la_xfer(input logic w, input logic [7:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] rd, output int en_cnt,
                         output logic [31:0] a_seen, output logic [31:0] we_seen);
    @(negedge clk);
    la_req = 1'b1; la_we = w; la_addr = a; la_wdata = d;
    lat = -1; rd = 32'h0; en_cnt = 0; a_seen = 32'h0; we_seen = 32'h0;
    for (int k = 1; k <= 8 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (ram_en_o) begin en_cnt++; a_seen = 32'(ram_addr_o); we_seen = 32'(ram_we_o); end
      if (la_ack_o) begin lat = k; rd = la_rdata_o; end
    end
    @(posedge clk); #1;
    chk("la ack held while req high", 32'(la_ack_o), 32'h1);
    @(negedge clk);
    la_req = 1'b0;
    @(posedge clk); #1;
    chk("la ack drops after req low", 32'(la_ack_o), 32'h0);
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    bit          hit;
    logic [31:0] eaddr;
    logic [31:0] ewe;
    logic [31:0] erd;
  } vec_t;

  initial begin
    vec_t v[7];
    int lat, en_cnt, cnt, first_rel;
    logic [31:0] rd, a_seen, we_seen, wd_seen;
    int g[3];
    int ng;
    logic la_drop, la_raise;

    v[0] = '{1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'b0011, 1'b1, 32'h04, 32'h3, 32'h0};
    v[1] = '{1'b0, 32'h3000_0010, 32'h0,         4'b1111, 1'b1, 32'h04, 32'h0, 32'h0000_BEEF};
    v[2] = '{1'b1, 32'h3000_03FC, 32'hA5A5_5A5A, 4'b1111, 1'b1, 32'hFF, 32'hF, 32'h0};
    v[3] = '{1'b0, 32'h3000_03FC, 32'h0,         4'b1111, 1'b1, 32'hFF, 32'h0, 32'hA5A5_5A5A};
    v[4] = '{1'b0, 32'h2000_0000, 32'h0,         4'b1111, 1'b0, 32'h00, 32'h0, 32'h0};
    v[5] = '{1'b1, 32'h3000_0400, 32'h1234_5678, 4'b1111, 1'b0, 32'h00, 32'h0, 32'h0};
    v[6] = '{1'b0, 32'h3000_0000, 32'h0,         4'b1111, 1'b1, 32'h00, 32'h0, 32'h0};

    rst_n = 1'b0; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat = 0;
    prog = 0; la_req = 0; la_we = 0; la_addr = 0; la_wdata = 0;

    // Reset values and first core release
    repeat (2) @(posedge clk); #1;
    chk("rst wbs_ack", 32'(wbs_ack_o), 0);
    chk("rst wbs_dat", wbs_dat_o, 0);
    chk("rst la_ack", 32'(la_ack_o), 0);
    chk("rst la_rdata", la_rdata_o, 0);
    chk("rst ram_en", 32'(ram_en_o), 0);
    chk("rst ram_we", 32'(ram_we_o), 0);
    chk("rst ram_addr", 32'(ram_addr_o), 0);
    chk("rst ram_wdata", ram_wdata_o, 0);
    chk("rst core_rst_no", 32'(core_rst_no), 0);
    @(negedge clk); rst_n = 1'b1;
    first_rel = -1;
    for (int k = 1; k <= 20 && first_rel < 0; k++) begin
      @(posedge clk); #1;
      if (core_rst_no) first_rel = k;
    end
    chk("first core release cycle", first_rel, 16);

    // Table-driven Wishbone transfers
    for (int i = 0; i < 7; i++) begin
      wb_xfer(v[i].w, v[i].a, v[i].d, v[i].s, lat, rd, en_cnt, a_seen, we_seen, wd_seen);
      chk($sformatf("v%0d ack latency", i), lat, v[i].hit ? 3 : 1);
      chk($sformatf("v%0d ram_en count", i), en_cnt, v[i].hit ? 1 : 0);
      if (v[i].hit) begin
        chk($sformatf("v%0d ram_addr", i), a_seen, v[i].eaddr);
        chk($sformatf("v%0d ram_we", i), we_seen, v[i].ewe);
        if (v[i].w) chk($sformatf("v%0d ram_wdata", i), wd_seen, v[i].d);
      end
      chk($sformatf("v%0d wbs_dat", i), rd, v[i].erd);
    end

    // LA programming port
    @(negedge clk); prog = 1'b1;
    la_xfer(1'b1, 8'h7F, 32'h1234_5678, lat, rd, en_cnt, a_seen, we_seen);
    chk("la wr latency", lat, 3);
    chk("la wr ram_en count", en_cnt, 1);
    chk("la wr ram_addr", a_seen, 32'h7F);
    chk("la wr ram_we", we_seen, 32'hF);
    chk("la wr core held", 32'(core_rst_no), 0);
    la_xfer(1'b0, 8'h7F, 32'h0, lat, rd, en_cnt, a_seen, we_seen);
    chk("la rd data", rd, 32'h1234_5678);
    chk("la rd ram_we", we_seen, 32'h0);
    wb_xfer(1'b0, 32'h3000_01FC, 32'h0, 4'hF, lat, rd, en_cnt, a_seen, we_seen, wd_seen);
    chk("wb sees la data", rd, 32'h1234_5678);

    // LA ignored outside programming mode; countdown must not release early
    @(negedge clk); prog = 1'b0; la_req = 1'b1; la_we = 1'b0; la_addr = 8'h7F;
    cnt = 0; first_rel = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (la_ack_o || ram_en_o) cnt++;
      if (core_rst_no) first_rel++;
    end
    chk("la ignored without prog", cnt, 0);
    @(negedge clk); la_req = 1'b0; prog = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); prog = 1'b0;
    first_rel = -1;
    for (int k = 1; k <= 20 && first_rel < 0; k++) begin
      @(posedge clk); #1;
      if (core_rst_no) first_rel = k;
    end
    chk("release after reload", first_rel, 16);

    // WB abort: cyc drops during ACC, ack suppressed
    @(negedge clk); cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0010;
    @(posedge clk); #1;
    chk("abort ram_en in ACC", 32'(ram_en_o), 1);
    @(negedge clk); cyc = 1'b0; stb = 1'b0;
    cnt = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (wbs_ack_o || wbs_dat_o != 32'h0) cnt++;
    end
    chk("abort no ack", cnt, 0);
    wb_xfer(1'b0, 32'h3000_0010, 32'h0, 4'hF, lat, rd, en_cnt, a_seen, we_seen, wd_seen);
    chk("post-abort latency", lat, 3);
    chk("post-abort data", rd, 32'h0000_BEEF);

    // Round-robin with both requesters continuously pending
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; prog = 1'b1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0004;
    la_req = 1'b1; la_we = 1'b0; la_addr = 8'h02;
    ng = 0;
    for (int k = 0; k < 40 && ng < 3; k++) begin
      @(posedge clk); #1;
      if (ram_en_o) begin g[ng] = int'(ram_addr_o); ng++; end
      la_drop  = la_ack_o && la_req;
      la_raise = !la_ack_o && !la_req;
      @(negedge clk);
      if (la_drop) la_req = 1'b0;
      else if (la_raise) la_req = 1'b1;
    end
    chk("rr grant count", ng, 3);
    chk("rr grant 1 WB", g[0], 1);
    chk("rr grant 2 LA", g[1], 2);
    chk("rr grant 3 WB", g[2], 1);
    @(negedge clk); cyc = 1'b0; stb = 1'b0; la_req = 1'b0; prog = 1'b0;
    repeat (8) @(posedge clk);

    // Asynchronous reset in the middle of an access
    @(negedge clk); cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0010;
    @(posedge clk); #1;
    chk("pre-reset ram_en", 32'(ram_en_o), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst ram_en", 32'(ram_en_o), 0);
    chk("async rst wbs_ack", 32'(wbs_ack_o), 0);
    chk("async rst la_ack", 32'(la_ack_o), 0);
    chk("async rst core_rst_no", 32'(core_rst_no), 0);
    @(negedge clk); cyc = 1'b0; stb = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    wb_xfer(1'b0, 32'h3000_0010, 32'h0, 4'hF, lat, rd, en_cnt, a_seen, we_seen, wd_seen);
    chk("post-reset latency", lat, 3);
    chk("post-reset data", rd, 32'h0000_BEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
Shares the single-port DFFRAM instruction memory of the Ibtida core between two loaders: the Caravel Wishbone slave (management firmware) and a logic-analyzer (LA) driven programming port. It arbitrates with round-robin and runs a fixed 4-cycle RAM access sequence. It also sequences the core reset: the core is held in reset during programming and for a hold time after programming ends. It sits inside the user project top, between the wrapper-level bus/LA signals and the memory macro.

Parameters:
ADDR_W, 8, RAM word-address width (256 x 32-bit words)
WB_BASE, 32'h3000_0000, Wishbone base address of the RAM window
RST_HOLD, 16, cycles core_rst_no stays low after prog_mode_i falls (1..65535)

Ports:
wb_clk_i  in  1  single clock
wb_rst_ni  in  1  asynchronous active-low reset
wbs_cyc_i  in  1  Wishbone cycle
wbs_stb_i  in  1  Wishbone strobe
wbs_we_i  in  1  Wishbone write enable
wbs_sel_i  in  4  byte selects
wbs_adr_i  in  32  byte address
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  one-cycle ack pulse
wbs_dat_o  out  32  read data, valid with ack
prog_mode_i  in  1  programming mode, from an LA bit
la_req_i  in  1  LA 4-phase request
la_we_i  in  1  LA write enable
la_addr_i  in  ADDR_W  LA word address
la_wdata_i  in  32  LA write data
la_ack_o  out  1  LA 4-phase acknowledge
la_rdata_o  out  32  LA read data, valid while la_ack_o=1
ram_en_o  out  1  RAM enable
ram_we_o  out  4  RAM byte write enables
ram_addr_o  out  ADDR_W  RAM word address
ram_wdata_o  out  32  RAM write data
ram_rdata_i  in  32  RAM read data, valid 1 cycle after ram_en_o
core_rst_no  out  1  active-low core reset

Behaviour:
- Reset (wb_rst_ni=0, asynchronous):
  - All outputs are 0, including core_rst_no (core held in reset).
  - FSM goes to IDLE, hold counter = RST_HOLD, last_owner = LA.
- WB request valid: wbs_cyc_i & wbs_stb_i & no WB transaction in flight.
  - Hit: wbs_adr_i[31:ADDR_W+2] == WB_BASE[31:ADDR_W+2].
  - RAM word address = wbs_adr_i[ADDR_W+1:2].
  - Miss: no RAM access; wbs_ack_o=1 and wbs_dat_o=0 on the next cycle (no bus hang).
- LA request pending: la_req_i=1 & la_ack_o=0 & prog_mode_i=1.
  - LA requests with prog_mode_i=0 are ignored (no ack).
- FSM states: IDLE -> ACC -> CAP -> RSP -> IDLE. Outputs are registered.
  - IDLE: if any hit is pending, latch owner/address/data/we/sel. Next state ACC.
  - Tie (both pending): grant the requester != last_owner. Update last_owner on every grant.
  - ACC: ram_en_o=1; ram_we_o = owner WB ? (wbs_we_i ? wbs_sel_i : 0) : (la_we_i ? 4'hF : 0).
  - CAP: register ram_rdata_i; write data is 0 on writes.
  - RSP, owner WB: wbs_ack_o=1 for exactly one cycle, with wbs_dat_o. The request is sampled at cycle N, so ack occurs at N+3.
  - RSP, owner LA: set la_ack_o=1 and la_rdata_o. la_ack_o stays 1 until the cycle after la_req_i is seen 0, then clears.
  - A new LA request is not accepted until la_ack_o=0.
- Abort: wbs_cyc_i drops before RSP.
  - The RAM access still completes and the ack is suppressed.
  - wbs_dat_o/wbs_ack_o stay 0.
- Core reset sequencing:
  - prog_mode_i=1: core_rst_no=0 and the counter reloads to RST_HOLD.
  - prog_mode_i=0: the counter decrements to 0. core_rst_no=1 only when the counter is 0.
  - First release after reset occurs RST_HOLD cycles after reset deassertion, provided prog_mode_i=0.
  - prog_mode_i re-asserting during the countdown reloads the counter; no glitch on core_rst_no.
- prog_mode_i falling mid LA transaction: the transaction completes and its ack protocol finishes normally.

Decomposition:
- Shared package ibtida_mem_pkg holds:
  - FSM state enum {IDLE, ACC, CAP, RSP}
  - owner enum {OWN_WB, OWN_LA}
  - RAM_DW=32 constant
- One sub-module: rst_hold_seq (prog_mode_i -> core_rst_no counter).
- Arbiter and FSM remain in the top module.

Test Plan:
- Reset, prog_mode_i=0 -> core_rst_no=0 for exactly 16 cycles after wb_rst_ni rises, then 1; all other outputs 0.
- WB write adr=0x3000_0010, dat=0xDEADBEEF, sel=4'b0011 -> ram_addr_o=4, ram_we_o=4'b0011 in ACC; ack at N+3. Readback of the same address returns 0xDEADBEEF masked by the RAM model to the written bytes.
- prog_mode_i=1, LA write addr=0x7F, data=0x12345678, then LA read of the same address -> la_rdata_o=0x12345678 with 4-phase handshake; la_ack_o drops one cycle after la_req_i drops.
- WB and LA pending in the same IDLE cycle, repeated 3 times from reset -> grant order WB, LA, WB.
- WB read adr=0x2000_0000 (miss) -> ack next cycle, dat=0, ram_en_o never asserted.
- wb_rst_ni asserted during ACC -> ram_en_o, acks and core_rst_no go 0 immediately; after release, the FSM is IDLE and a fresh WB read completes normally.
